sim_status_collector: RTL

// - Parametrised successor to the single-DUT sim status hookup: aggregates NCH independent sub-test channels into
//   the sim_success / sim_done / sim_report outputs read by the CI bench.
// - Round-robin arbitrates channel report words into a FIFO, drains them to the bench with valid/ready,

---
 rtl/sim_status_collector.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/sim_status_collector.sv
// Aggregates NCH sub-test channels: round-robin report FIFO, sticky done/pass latches, run-complete FSM.
// Optional watchdog enabled by defining SIM_COLLECT_TIMEOUT_EN.
module sim_status_collector #(
  parameter int unsigned NCH        = 4,
  parameter int unsigned REPORT_W   = 32,
  parameter int unsigned FIFO_DEPTH = 8,
  parameter int unsigned TIMEOUT    = 800000
) (
  input  logic                    refclk,
  input  logic                    rst_n,
  input  logic [NCH-1:0]          ch_valid,
  input  logic [NCH*REPORT_W-1:0] ch_report,
  output logic [NCH-1:0]          ch_ready,
  input  logic [NCH-1:0]          ch_done,
  input  logic [NCH-1:0]          ch_pass,
  output logic [REPORT_W-1:0]     sim_report,
  output logic                    sim_report_vld,
  input  logic                    sim_report_rdy,
  output logic                    sim_done,
  output logic                    sim_success
);

  localparam int unsigned PW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  typedef enum logic [1:0] {StRun, StDrain, StDone} state_e;

  state_e                state_q;
  logic                  sim_done_q;
  logic                  sim_success_q;
  logic                  to_hit_q;

  logic [PW-1:0]         rr_q;
  logic [NCH-1:0]        grant;
  logic [PW-1:0]         gnt_idx;
  logic                  gnt_found;
  logic [PW-1:0]         rr_next;

  logic [REPORT_W-1:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]         rd_ptr_q;
  logic [AW-1:0]         wr_ptr_q;
  logic [AW:0]           count_q;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  accept_en;
  logic                  push;
  logic                  pop;
  logic [REPORT_W-1:0]   push_word;

  logic [NCH-1:0]        done_q;
  logic [NCH-1:0]        pass_q;
  logic                  all_done;
  logic                  drain_done;

  logic                  to_fire;
  logic                  to_vld;
  logic [REPORT_W-1:0]   to_word;

  // Round-robin search starting at the pointer, wrapping at NCH.
  always_comb begin
    int unsigned idx;
    grant     = '0;
    gnt_idx   = '0;
    gnt_found = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < NCH; i++) begin
      idx = 32'(rr_q) + i;
      if (idx >= NCH) begin
        idx = idx - NCH;
      end
      if (!gnt_found && ch_valid[idx]) begin
        gnt_found  = 1'b1;
        grant[idx] = 1'b1;
        gnt_idx    = PW'(idx);
      end
    end
  end

  always_comb begin
    rr_next = '0;
    if (32'(gnt_idx) != NCH - 1) begin
      rr_next = gnt_idx + PW'(1);
    end
  end

  assign fifo_full  = (count_q == (AW + 1)'(FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);
  assign accept_en  = (state_q != StDone) && !fifo_full && !to_fire;
  assign ch_ready   = accept_en ? grant : '0;
  assign push       = accept_en && gnt_found;
  assign pop        = !fifo_empty && sim_report_rdy;
  assign push_word  = ch_report[gnt_idx*REPORT_W +: REPORT_W];

  assign all_done   = &done_q;
  assign drain_done = (state_q == StDrain) && fifo_empty && !(|ch_valid);

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      rr_q <= '0;
    end else if (push) begin
      rr_q <= rr_next;
    end
  end

  // Storage is reset so the head reads 0 out of reset; sim_report is the entry under rd_ptr.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (to_fire) begin
      mem_q[0] <= to_word;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= push_word;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      if (push && !pop) begin
        count_q <= count_q + (AW + 1)'(1);
      end else if (pop && !push) begin
        count_q <= count_q - (AW + 1)'(1);
      end
    end
  end

  assign sim_report     = mem_q[rd_ptr_q];
  assign sim_report_vld = !fifo_empty || to_vld;

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      done_q <= '0;
      pass_q <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        if (ch_done[i] && !done_q[i]) begin
          done_q[i] <= 1'b1;
          pass_q[i] <= ch_pass[i];
        end
      end
    end
  end

`ifdef SIM_COLLECT_TIMEOUT_EN
  logic [31:0] cnt_q;
  logic        to_vld_q;

  // Normal DONE entry takes priority over a coincident timeout.
  assign to_fire = (state_q == StRun || state_q == StDrain) && (cnt_q == 32'(TIMEOUT - 1))
                   && !drain_done;
  assign to_vld  = to_vld_q;

  always_comb begin
    to_word                    = '0;
    to_word[NCH-1:0]           = ~done_q;
    to_word[REPORT_W-1 -: 16]  = 16'hDEAD;
  end

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= '0;
      to_vld_q <= 1'b0;
    end else begin
      to_vld_q <= to_fire;
      if (state_q == StRun || state_q == StDrain) begin
        cnt_q <= cnt_q + 32'd1;
      end
    end
  end
`else
  assign to_fire = 1'b0;
  assign to_vld  = 1'b0;
  assign to_word = '0;
`endif

  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StRun;
      sim_done_q    <= 1'b0;
      sim_success_q <= 1'b0;
      to_hit_q      <= 1'b0;
    end else begin
      unique case (state_q)
        StRun: begin
          if (to_fire) begin
            state_q  <= StDone;
            to_hit_q <= 1'b1;
          end else if (all_done) begin
            state_q <= StDrain;
          end
        end
        StDrain: begin
          if (drain_done) begin
            state_q <= StDone;
          end else if (to_fire) begin
            state_q  <= StDone;
            to_hit_q <= 1'b1;
          end
        end
        StDone: begin
          sim_done_q    <= 1'b1;
          sim_success_q <= all_done && (&pass_q) && !to_hit_q;
        end
        default: state_q <= StRun;
      endcase
    end
  end

  assign sim_done    = sim_done_q;
  assign sim_success = sim_success_q;

endmodule
